// File: rtl/dpram_arbiter_if.sv
// Bus bundle between client A, client B, the arbiter and one port of the dual-port RAM.
// The arbiter uses the slave modport; the clients/RAM side uses the master modport.
interface dpram_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dpram_arbiter.sv
// Two-client round-robin/burst arbiter for one RAM port with owner-tagged read return.
// Optional macro DPRAM_ARB_PRIO_A_EN switches to fixed priority for client A.
module dpram_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    dpram_arbiter_if.slave  io_bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;
    localparam logic [CNT_W-1:0] BURST_L = CNT_W'(BURST_LEN);
    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_ptr;
    logic              w_ptr_nxt;
    logic              w_gnt_a;
    logic              w_gnt_b;

    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_owner_b;

    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    // State, burst counter and priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= PTR_A;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Grant decode and next-state; grants are suppressed while reset is held
    always_comb begin
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
`ifdef DPRAM_ARB_PRIO_A_EN
        w_gnt_a     = rst_n & io_bus.a_req;
        w_gnt_b     = rst_n & io_bus.b_req & ~io_bus.a_req;
        w_state_nxt = ST_IDLE;
`else
        if (rst_n) begin
            unique case (r_state)
                ST_OWN_A: begin
                    if (io_bus.a_req && ((r_cnt < BURST_L) || !io_bus.b_req)) begin
                        w_gnt_a   = 1'b1;
                        w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 4'd1;
                    end else if (io_bus.b_req) begin
                        w_gnt_b     = 1'b1;
                        w_state_nxt = ST_OWN_B;
                        w_cnt_nxt   = 4'd1;
                        w_ptr_nxt   = PTR_A;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = PTR_B;
                    end
                end
                ST_OWN_B: begin
                    if (io_bus.b_req && ((r_cnt < BURST_L) || !io_bus.a_req)) begin
                        w_gnt_b   = 1'b1;
                        w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 4'd1;
                    end else if (io_bus.a_req) begin
                        w_gnt_a     = 1'b1;
                        w_state_nxt = ST_OWN_A;
                        w_cnt_nxt   = 4'd1;
                        w_ptr_nxt   = PTR_B;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = PTR_A;
                    end
                end
                default: begin
                    if (io_bus.a_req && (!io_bus.b_req || (r_ptr == PTR_A))) begin
                        w_gnt_a     = 1'b1;
                        w_state_nxt = ST_OWN_A;
                        w_cnt_nxt   = 4'd1;
                    end else if (io_bus.b_req) begin
                        w_gnt_b     = 1'b1;
                        w_state_nxt = ST_OWN_B;
                        w_cnt_nxt   = 4'd1;
                    end
                end
            endcase
        end
`endif
    end

    // Stage 1: registered RAM command plus owner tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_owner_b   <= 1'b0;
        end else begin
            r_ram_en  <= w_gnt_a | w_gnt_b;
            r_owner_b <= w_gnt_b;
            if (w_gnt_b) begin
                r_ram_we    <= io_bus.b_we;
                r_ram_addr  <= io_bus.b_addr;
                r_ram_wdata <= io_bus.b_wdata;
            end else begin
                r_ram_we    <= w_gnt_a & io_bus.a_we;
                r_ram_addr  <= io_bus.a_addr;
                r_ram_wdata <= io_bus.a_wdata;
            end
        end
    end

    // Stage 2: read-valid to the owner; data holder keeps the last returned byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= r_ram_en & ~r_ram_we & ~r_owner_b;
            r_b_rvalid <= r_ram_en & ~r_ram_we &  r_owner_b;
            if (r_a_rvalid) r_a_rdata <= io_bus.ram_rdata;
            if (r_b_rvalid) r_b_rdata <= io_bus.ram_rdata;
        end
    end

    // ram_rdata is already the RAM's output register, so it is forwarded in the rvalid cycle
    assign io_bus.a_gnt     = w_gnt_a;
    assign io_bus.b_gnt     = w_gnt_b;
    assign io_bus.a_rvalid  = r_a_rvalid;
    assign io_bus.b_rvalid  = r_b_rvalid;
    assign io_bus.a_rdata   = r_a_rvalid ? io_bus.ram_rdata : r_a_rdata;
    assign io_bus.b_rdata   = r_b_rvalid ? io_bus.ram_rdata : r_b_rdata;
    assign io_bus.ram_en    = r_ram_en;
    assign io_bus.ram_we    = r_ram_we;
    assign io_bus.ram_addr  = r_ram_addr;
    assign io_bus.ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed self-checking bench for dpram_arbiter with a behavioural 1K x 8 RAM port.
module tb_dpram_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    dpram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    dpram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_if.slave)
    );

    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] ram_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read data, valid the cycle after ram_en
    always @(posedge clk) begin
        if (bus_if.ram_en) begin
            if (bus_if.ram_we) mem[bus_if.ram_addr] <= bus_if.ram_wdata;
            else               ram_q <= mem[bus_if.ram_addr];
        end
    end
    assign bus_if.ram_rdata = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [9:0] addr, input logic [7:0] wd);
        bus_if.a_req = req; bus_if.a_we = we; bus_if.a_addr = addr; bus_if.a_wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [9:0] addr, input logic [7:0] wd);
        bus_if.b_req = req; bus_if.b_we = we; bus_if.b_addr = addr; bus_if.b_wdata = wd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic exp_a;
        n_tests = 0;
        n_fail  = 0;
        ram_q   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset held with both clients requesting
        rst_n = 1'b0;
        drive_a(1'b1, 1'b0, 10'h000, 8'h00);
        drive_b(1'b1, 1'b0, 10'h001, 8'h00);
        step(); step();
        chk("rst_a_gnt",    32'(bus_if.a_gnt),    32'd0);
        chk("rst_b_gnt",    32'(bus_if.b_gnt),    32'd0);
        chk("rst_a_rvalid", 32'(bus_if.a_rvalid), 32'd0);
        chk("rst_b_rvalid", 32'(bus_if.b_rvalid), 32'd0);
        chk("rst_ram_en",   32'(bus_if.ram_en),   32'd0);
        rst_n = 1'b1;
        settle();
        chk("rel_first_gnt_a", 32'(bus_if.a_gnt), 32'd1);
        chk("rel_first_gnt_b", 32'(bus_if.b_gnt), 32'd0);
        drive_a(1'b0, 1'b0, 10'h000, 8'h00);
        drive_b(1'b0, 1'b0, 10'h000, 8'h00);
        do_reset();

        // Client A: write 0x005=0x0A, then read it back
        step();
        drive_a(1'b1, 1'b1, 10'h005, 8'h0A);
        settle();
        chk("wr_a_gnt", 32'(bus_if.a_gnt), 32'd1);
        step();
        drive_a(1'b1, 1'b0, 10'h005, 8'h00);
        settle();
        chk("rd_a_gnt",     32'(bus_if.a_gnt),     32'd1);
        chk("wr_ram_en",    32'(bus_if.ram_en),    32'd1);
        chk("wr_ram_we",    32'(bus_if.ram_we),    32'd1);
        chk("wr_ram_addr",  32'(bus_if.ram_addr),  32'h005);
        chk("wr_ram_wdata", 32'(bus_if.ram_wdata), 32'h0A);
        step();
        drive_a(1'b0, 1'b0, 10'h000, 8'h00);
        settle();
        chk("rd_ram_en",    32'(bus_if.ram_en),   32'd1);
        chk("rd_ram_we",    32'(bus_if.ram_we),   32'd0);
        chk("rd_early_rv",  32'(bus_if.a_rvalid), 32'd0);
        step();
        chk("rd_a_rvalid",  32'(bus_if.a_rvalid), 32'd1);
        chk("rd_a_rdata",   32'(bus_if.a_rdata),  32'h0A);
        chk("rd_b_rvalid",  32'(bus_if.b_rvalid), 32'd0);
        chk("rd_idle_en",   32'(bus_if.ram_en),   32'd0);
        step();
        chk("rd_rv_pulse",  32'(bus_if.a_rvalid), 32'd0);
        chk("rd_hold",      32'(bus_if.a_rdata),  32'h0A);

        // Contention: both clients write continuously
        do_reset();
        step();
        drive_a(1'b1, 1'b1, 10'h010, 8'h11);
        drive_b(1'b1, 1'b1, 10'h020, 8'h22);
        for (int i = 0; i < 12; i++) begin
            settle();
`ifdef DPRAM_ARB_PRIO_A_EN
            exp_a = 1'b1;
`else
            exp_a = ((i % 8) < 4);
`endif
            chk($sformatf("cont_a_gnt[%0d]", i), 32'(bus_if.a_gnt), 32'(exp_a));
            chk($sformatf("cont_b_gnt[%0d]", i), 32'(bus_if.b_gnt), 32'(!exp_a));
            if (i > 0) chk($sformatf("cont_ram_en[%0d]", i), 32'(bus_if.ram_en), 32'd1);
            step();
        end
        drive_a(1'b0, 1'b0, 10'h000, 8'h00);
        drive_b(1'b0, 1'b0, 10'h000, 8'h00);

        // Single requester B for 10 cycles, then release; pointer must return to A
        do_reset();
        step();
        drive_b(1'b1, 1'b1, 10'h030, 8'h33);
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("solo_b_gnt[%0d]", i), 32'(bus_if.b_gnt), 32'd1);
            chk($sformatf("solo_a_gnt[%0d]", i), 32'(bus_if.a_gnt), 32'd0);
            step();
        end
        drive_b(1'b0, 1'b0, 10'h000, 8'h00);
        step();
        drive_a(1'b1, 1'b1, 10'h031, 8'h44);
        drive_b(1'b1, 1'b1, 10'h032, 8'h45);
        settle();
        chk("solo_ptr_a_gnt", 32'(bus_if.a_gnt), 32'd1);
        chk("solo_ptr_b_gnt", 32'(bus_if.b_gnt), 32'd0);
        step();
        drive_a(1'b0, 1'b0, 10'h000, 8'h00);
        drive_b(1'b0, 1'b0, 10'h000, 8'h00);

        // Same-address race: A writes 0x3FF=0x55, B reads 0x3FF
        do_reset();
        step();
        drive_a(1'b1, 1'b1, 10'h3FF, 8'h55);
        drive_b(1'b1, 1'b0, 10'h3FF, 8'h00);
        settle();
        chk("race_a_first", 32'(bus_if.a_gnt), 32'd1);
        chk("race_b_wait",  32'(bus_if.b_gnt), 32'd0);
        step();
        drive_a(1'b0, 1'b0, 10'h000, 8'h00);
        settle();
        chk("race_b_gnt", 32'(bus_if.b_gnt), 32'd1);
        step();
        drive_b(1'b0, 1'b0, 10'h000, 8'h00);
        settle();
        chk("race_ram_addr", 32'(bus_if.ram_addr), 32'h3FF);
        chk("race_ram_we",   32'(bus_if.ram_we),   32'd0);
        step();
        chk("race_b_rvalid", 32'(bus_if.b_rvalid), 32'd1);
        chk("race_b_rdata",  32'(bus_if.b_rdata),  32'h55);
        chk("race_a_rvalid", 32'(bus_if.a_rvalid), 32'd0);

        // Reset one cycle after a read grant: the read must vanish
        step();
        drive_a(1'b1, 1'b0, 10'h005, 8'h00);
        settle();
        chk("mid_a_gnt", 32'(bus_if.a_gnt), 32'd1);
        step();
        drive_a(1'b0, 1'b0, 10'h000, 8'h00);
        rst_n = 1'b0;
        settle();
        chk("mid_ram_en_drop", 32'(bus_if.ram_en), 32'd0);
        step();
        rst_n = 1'b1;
        settle();
        chk("mid_no_rv0", 32'(bus_if.a_rvalid), 32'd0);
        step();
        chk("mid_no_rv1", 32'(bus_if.a_rvalid), 32'd0);
        drive_a(1'b1, 1'b0, 10'h3FF, 8'h00);
        settle();
        chk("post_a_gnt", 32'(bus_if.a_gnt), 32'd1);
        step();
        drive_a(1'b0, 1'b0, 10'h000, 8'h00);
        step();
        chk("post_a_rvalid", 32'(bus_if.a_rvalid), 32'd1);
        chk("post_a_rdata",  32'(bus_if.a_rdata),  32'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
